// File: rtl/ifetch_pkg.sv
// Shared definitions for the instruction fetch stage: reset PC, FSM
// encoding, instruction field positions and the PC increment.
package ifetch_pkg;

    localparam logic [31:0] PC_RESET_DEFAULT = 32'h0000_3000;
    localparam logic [31:0] PC_STEP          = 32'd4;

    localparam int OP_MSB    = 31;
    localparam int OP_LSB    = 26;
    localparam int FUNCT_MSB = 5;
    localparam int FUNCT_LSB = 0;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_WAIT  = 2'd2
    } fetch_state_e;

    function automatic logic [31:0] word_align(input logic [31:0] addr);
        return {addr[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/ifetch_fifo.sv
// Two-entry circular buffer of {pc, inst} pairs between fetch and decode.
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   push, push_data     write one entry (never issued when full)
//   pop                 drop the head entry
//   flush               empty the buffer; overrides push and pop
//   head                current head entry, read combinationally
//   count               number of valid entries (0..2)
module ifetch_fifo (
    input  logic        clk,
    input  logic        rst,
    input  logic        push,
    input  logic [63:0] push_data,
    input  logic        pop,
    input  logic        flush,
    output logic [63:0] head,
    output logic [1:0]  count
);
    logic [63:0] mem_q [2];
    logic [63:0] mem_d [2];
    logic        wr_ptr_q, wr_ptr_d;
    logic        rd_ptr_q, rd_ptr_d;
    logic [1:0]  count_q, count_d;

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush) begin
            wr_ptr_d = 1'b0;
            rd_ptr_d = 1'b0;
            count_d  = 2'd0;
        end else begin
            if (push) begin
                mem_d[wr_ptr_q] = push_data;
                wr_ptr_d        = ~wr_ptr_q;
            end
            if (pop) begin
                rd_ptr_d = ~rd_ptr_q;
            end
            count_d = count_q + {1'b0, push} - {1'b0, pop};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            count_q  <= 2'd0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage carries no reset; validity is tracked by count alone.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

    assign head  = mem_q[rd_ptr_q];
    assign count = count_q;

endmodule

// File: rtl/ifetch_unit.sv
// Instruction fetch stage: owns the PC, runs the req/ack handshake to
// instruction memory and feeds decode through a 2-entry buffer.
//
// state | meaning
// IDLE  | one cycle after reset, no request
// FETCH | request outstanding at pc (imem_req=1)
// WAIT  | buffer full, request withheld
//
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   imem_req/addr            request to memory, held until imem_ack
//   imem_ack/rdata           memory response
//   inst_valid/ready         head handshake to decode
//   inst_out/inst_pc         head instruction and its PC (0 when empty)
//   op/funct                 opcode and function fields of inst_out
//   redirect_valid/pc        load new PC and flush the buffer
module ifetch_unit
    import ifetch_pkg::*;
#(
    parameter logic [31:0] PC_RESET   = PC_RESET_DEFAULT,
    parameter int          FIFO_DEPTH = 2
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic        inst_valid,
    input  logic        inst_ready,
    output logic [31:0] inst_out,
    output logic [31:0] inst_pc,
    output logic [5:0]  op,
    output logic [5:0]  funct,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc
);
    localparam logic [1:0] FULL_COUNT = 2'(FIFO_DEPTH);

    fetch_state_e state_q, state_d;
    logic [31:0]  pc_q, pc_d;
    logic [31:0]  pend_pc_q, pend_pc_d;
    logic         discard_q, discard_d;

    logic         ack_fire;
    logic         push;
    logic         pop;
    logic [1:0]   count;
    logic [1:0]   count_next;
    logic [63:0]  head;
    logic [31:0]  redirect_tgt;

    assign ack_fire     = (state_q == ST_FETCH) && imem_ack;
    assign inst_valid   = (count != 2'd0);
    assign pop          = inst_valid && inst_ready;
    // A redirect drops whatever returns this cycle; a discarded fetch is stale.
    assign push         = ack_fire && !discard_q && !redirect_valid;
    assign redirect_tgt = word_align(redirect_pc);
    assign count_next   = redirect_valid ? 2'd0
                                         : count + {1'b0, push} - {1'b0, pop};

    ifetch_fifo u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (push),
        .push_data ({pc_q, imem_rdata}),
        .pop       (pop),
        .flush     (redirect_valid),
        .head      (head),
        .count     (count)
    );

    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        pend_pc_d = pend_pc_q;
        discard_d = discard_q;
        if (redirect_valid) begin
            if (state_q == ST_FETCH && !imem_ack) begin
                // Memory still owes us a word at pc_q; keep the address
                // stable and remember where to go once it arrives.
                discard_d = 1'b1;
                pend_pc_d = redirect_tgt;
            end else begin
                pc_d      = redirect_tgt;
                discard_d = 1'b0;
                state_d   = ST_FETCH;
            end
        end else begin
            unique case (state_q)
                ST_IDLE: state_d = ST_FETCH;
                ST_FETCH: begin
                    if (imem_ack) begin
                        if (discard_q) begin
                            pc_d      = pend_pc_q;
                            discard_d = 1'b0;
                        end else begin
                            pc_d = pc_q + PC_STEP;
                        end
                        state_d = (count_next < FULL_COUNT) ? ST_FETCH : ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (count_next < FULL_COUNT) state_d = ST_FETCH;
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            pc_q      <= word_align(PC_RESET);
            pend_pc_q <= word_align(PC_RESET);
            discard_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            pend_pc_q <= pend_pc_d;
            discard_q <= discard_d;
        end
    end

    assign imem_req  = (state_q == ST_FETCH);
    assign imem_addr = pc_q;
    assign inst_out  = inst_valid ? head[31:0]  : 32'h0;
    assign inst_pc   = inst_valid ? head[63:32] : 32'h0;
    assign op        = inst_out[OP_MSB:OP_LSB];
    assign funct     = inst_out[FUNCT_MSB:FUNCT_LSB];

endmodule

// File: tb/tb_ifetch_unit.sv
module tb_ifetch_unit;
    logic        clk;
    logic        rst;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic        inst_valid;
    logic        inst_ready;
    logic [31:0] inst_out;
    logic [31:0] inst_pc;
    logic [5:0]  op;
    logic [5:0]  funct;
    logic        redirect_valid;
    logic [31:0] redirect_pc;

    int n_cmp = 0;
    int n_bad = 0;

    ifetch_unit dut (
        .clk            (clk),
        .rst            (rst),
        .imem_req       (imem_req),
        .imem_addr      (imem_addr),
        .imem_ack       (imem_ack),
        .imem_rdata     (imem_rdata),
        .inst_valid     (inst_valid),
        .inst_ready     (inst_ready),
        .inst_out       (inst_out),
        .inst_pc        (inst_pc),
        .op             (op),
        .funct          (funct),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Reference model: request flag, PC bookkeeping and a queue for the buffer.
    bit          m_req;
    bit          m_idle;
    bit          m_discard;
    logic [31:0] m_pc;
    logic [31:0] m_pend;
    logic [63:0] m_q[$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s @%0t: got %h expected %h", tag, $time, obs, exp);
        end
    endtask

    task automatic model_step(input bit r, input bit a, input bit rdy,
                              input bit rv, input logic [31:0] rpc,
                              input logic [31:0] rd);
        bit          fire;
        logic [31:0] tgt;
        if (r) begin
            m_pc = 32'h0000_3000;
            m_q.delete();
            m_discard = 0;
            m_req = 0;
            m_idle = 1;
            return;
        end
        fire = m_req && a;
        tgt  = {rpc[31:2], 2'b00};
        if (rv) begin
            m_q.delete();
            if (m_req && !fire) begin
                m_discard = 1;
                m_pend = tgt;
            end else begin
                m_pc = tgt;
                m_discard = 0;
                m_req = 1;
            end
            m_idle = 0;
        end else begin
            if (m_q.size() > 0 && rdy) void'(m_q.pop_front());
            if (fire) begin
                if (m_discard) begin
                    m_pc = m_pend;
                    m_discard = 0;
                end else begin
                    m_q.push_back({m_pc, rd});
                    m_pc = m_pc + 32'd4;
                end
            end
            if (m_idle) begin
                m_idle = 0;
                m_req = 1;
            end else if (fire || !m_req) begin
                m_req = (m_q.size() < 2);
            end
        end
    endtask

    task automatic compare_all();
        logic [31:0] e_inst;
        logic [31:0] e_pc;
        e_inst = (m_q.size() > 0) ? m_q[0][31:0]  : 32'h0;
        e_pc   = (m_q.size() > 0) ? m_q[0][63:32] : 32'h0;
        chk("imem_req", {31'b0, imem_req}, {31'b0, m_req});
        if (m_req) chk("imem_addr", imem_addr, m_pc);
        chk("inst_valid", {31'b0, inst_valid}, {31'b0, m_q.size() > 0});
        chk("inst_out", inst_out, e_inst);
        chk("inst_pc", inst_pc, e_pc);
        chk("op", {26'b0, op}, {26'b0, e_inst[31:26]});
        chk("funct", {26'b0, funct}, {26'b0, e_inst[5:0]});
    endtask

    // Drive one cycle's inputs, advance the model, then check after the edge.
    task automatic cycle(input bit r, input bit a, input bit rdy,
                         input bit rv, input logic [31:0] rpc,
                         input logic [31:0] rd);
        rst            = r;
        imem_ack       = a;
        inst_ready     = rdy;
        redirect_valid = rv;
        redirect_pc    = rpc;
        imem_rdata     = rd;
        model_step(r, a, rdy, rv, rpc, rd);
        @(posedge clk);
        #1;
        compare_all();
    endtask

    // Zero-wait memory: ack follows the expected request.
    task automatic tied(input bit rdy);
        cycle(0, m_req, rdy, 0, 32'h0, $urandom);
    endtask

    task automatic do_reset();
        cycle(1, 0, 0, 0, 32'h0, 32'h0);
        cycle(1, 0, 0, 0, 32'h0, 32'h0);
    endtask

    initial begin
        rst = 1'b1; imem_ack = 1'b0; inst_ready = 1'b0;
        redirect_valid = 1'b0; redirect_pc = 32'h0; imem_rdata = 32'h0;

        // Reset outputs
        do_reset();
        chk("rst_req", {31'b0, imem_req}, 32'd0);
        chk("rst_valid", {31'b0, inst_valid}, 32'd0);
        chk("rst_inst", inst_out, 32'h0);

        // Streaming with zero-wait memory and decode always ready
        tied(1);                               // IDLE -> FETCH
        chk("s1_addr0", imem_addr, 32'h0000_3000);
        tied(1);
        chk("s1_addr1", imem_addr, 32'h0000_3004);
        chk("s1_pc0", inst_pc, 32'h0000_3000);
        tied(1);
        chk("s1_addr2", imem_addr, 32'h0000_3008);
        chk("s1_pc1", inst_pc, 32'h0000_3004);
        for (int i = 0; i < 6; i++) tied(1);

        // Fill buffer, then a single-cycle ready pulse
        do_reset();
        tied(0);
        tied(0);
        tied(0);
        chk("s2_full_req", {31'b0, imem_req}, 32'd0);
        chk("s2_head", inst_pc, 32'h0000_3000);
        tied(1);
        chk("s2_head2", inst_pc, 32'h0000_3004);
        chk("s2_rereq", {31'b0, imem_req}, 32'd1);
        chk("s2_addr", imem_addr, 32'h0000_3008);
        tied(0);

        // Redirect while a slow fetch is outstanding
        do_reset();
        cycle(0, 0, 1, 0, 32'h0, 32'h0);       // IDLE -> FETCH
        cycle(0, 0, 1, 0, 32'h0, 32'h0);
        cycle(0, 0, 1, 1, 32'h0000_3101, 32'h0);
        chk("s3_hold0", imem_addr, 32'h0000_3000);
        cycle(0, 0, 1, 0, 32'h0, 32'h0);
        chk("s3_hold1", imem_addr, 32'h0000_3000);
        cycle(0, 1, 1, 0, 32'h0, 32'hDEAD_BEEF);
        chk("s3_noval", {31'b0, inst_valid}, 32'd0);
        chk("s3_addr", imem_addr, 32'h0000_3100);
        tied(1);
        chk("s3_pc", inst_pc, 32'h0000_3100);
        tied(1);

        // Full buffer hit by redirect, ack and ready together
        do_reset();
        tied(0); tied(0); tied(0);
        cycle(0, 1, 1, 1, 32'h0000_3101, 32'h1234_5678);
        chk("s4_valid", {31'b0, inst_valid}, 32'd0);
        chk("s4_addr", imem_addr, 32'h0000_3100);
        tied(1);
        chk("s4_pc", inst_pc, 32'h0000_3100);

        // PC wrap at the top of the address space
        cycle(0, m_req, 1, 1, 32'hFFFF_FFFE, $urandom);
        chk("s5_addr0", imem_addr, 32'hFFFF_FFFC);
        tied(1);
        chk("s5_addr1", imem_addr, 32'h0000_0000);
        chk("s5_pc", inst_pc, 32'hFFFF_FFFC);
        tied(1);

        // Reset mid-fetch with ack pending, then a late ack in IDLE
        cycle(0, 0, 0, 0, 32'h0, 32'h0);
        cycle(1, 1, 1, 0, 32'h0, 32'hCAFE_0001);
        chk("s6_req", {31'b0, imem_req}, 32'd0);
        chk("s6_valid", {31'b0, inst_valid}, 32'd0);
        cycle(0, 1, 1, 0, 32'h0, 32'hCAFE_0002);
        chk("s6_valid2", {31'b0, inst_valid}, 32'd0);
        chk("s6_addr", imem_addr, 32'h0000_3000);

        // Randomized traffic against the model
        for (int i = 0; i < 4000; i++) begin
            bit          r, a, rdy, rv;
            logic [31:0] rpc;
            r   = ($urandom_range(0, 199) == 0);
            a   = ($urandom_range(0, 99) < 60);
            rdy = ($urandom_range(0, 99) < 70);
            rv  = ($urandom_range(0, 99) < 5);
            rpc = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(0, 15)))
                                             : $urandom;
            cycle(r, a, rdy, rv, rpc, $urandom);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/ifetch_unit.md
Name: ifetch_unit

Overview:
Instruction fetch stage directly upstream of the control decoder. It holds the PC and runs a req/ack handshake to instruction memory. Fetched words go into a 2-entry buffer, which presents the instruction, its PC and the split op/funct fields to decode. Redirects (branch/jump targets) flush the buffer and safely drop any in-flight fetch.

Parameters:
PC_RESET, 32'h0000_3000, PC loaded on reset
FIFO_DEPTH, 2, fetch buffer entries (fixed at 2; other values unsupported)

Ports:
clk  in  1  single clock, all state on rising edge
rst  in  1  synchronous reset, active-high
imem_req  out  1  fetch request, held until imem_ack
imem_addr  out  32  word address of request, low 2 bits always 00, stable while imem_req=1
imem_ack  in  1  response valid; sampled only when imem_req=1
imem_rdata  in  32  instruction word, valid with imem_ack
inst_valid  out  1  buffer head valid
inst_ready  in  1  decode accepts head this cycle
inst_out  out  32  head instruction (32'h0 when !inst_valid)
inst_pc  out  32  head PC (32'h0 when !inst_valid)
op  out  6  inst_out[31:26]
funct  out  6  inst_out[5:0]
redirect_valid  in  1  load new PC, flush buffer
redirect_pc  in  32  target; bits [1:0] ignored (forced 00)

Behaviour:
- Reset (rst=1 at edge): pc<=PC_RESET; state<=IDLE; buffer count<=0; discard<=0.
- Reset outputs: imem_req=0, inst_valid=0, inst_out/inst_pc/op/funct=0.
- Reset wins over every other input. An ack arriving during or after reset while imem_req=0 is ignored.
- States: IDLE, FETCH, WAIT. Encoding is shared via the package.
- IDLE: imem_req=0. Lasts one cycle after reset release, then FETCH.
- FETCH: imem_req=1, imem_addr=pc.
  - Zero-wait ack (ack in the same cycle req rises) is legal.
  - On ack with discard=0: push {pc, imem_rdata}; pc<=pc+4 (mod 2^32, so 32'hFFFF_FFFC wraps to 0).
  - On ack with discard=1: drop the data; pc<=pend_pc; discard<=0.
- Next state after an ack is computed from next-cycle count (push/pop applied): count<2 -> FETCH (new request next cycle); count==2 -> WAIT.
- WAIT: imem_req=0. Moves to FETCH in the cycle after count drops below 2.
- Pop: when inst_valid & inst_ready. Push and pop in the same cycle leave count unchanged. Push never occurs at count 2, because no request is issued when full.
- Redirect (priority over push/pop):
  - Buffer count<=0, so inst_valid=0 next cycle.
  - If FETCH and no ack this cycle (request outstanding): discard<=1, pend_pc<=redirect_pc. imem_addr stays unchanged until ack.
  - If ack in the same cycle: data dropped, pc<=redirect_pc, stay or enter FETCH.
  - If IDLE or WAIT: pc<=redirect_pc, next state FETCH.
  - A second redirect while discard=1 overwrites pend_pc.
- Latency: an ack in cycle N makes inst_valid=1 in cycle N+1 if the buffer was empty. Throughput is 1 instr/cycle with zero-wait memory and inst_ready=1.
- Buffer: circular, 1-bit rd/wr pointers plus 2-bit count. Head is read combinationally.

Decomposition:
- Package ifetch_pkg: PC_RESET default, state encoding (IDLE/FETCH/WAIT), OP_MSB=31, OP_LSB=26, FUNCT_MSB=5, FUNCT_LSB=0, PC_STEP=4.
- Sub-module ifetch_fifo: 2-entry {pc, inst} buffer.
  - Ports: clk, rst, push, push_data[63:0], pop, flush, head[63:0], count[1:0].
  - flush overrides push/pop.

Test Plan:
- Reset release, imem_ack tied to imem_req, inst_ready=1 -> imem_addr 0x3000, 0x3004, 0x3008 on consecutive cycles; inst_pc follows one cycle later; op/funct match the returned words.
- inst_ready=0, zero-wait memory -> two pushes (0x3000, 0x3004), imem_req drops, count 2. One-cycle inst_ready pulse -> head becomes 0x3004 and imem_req reasserts with addr 0x3008 the next cycle.
- Ack delayed 3 cycles; redirect_pc=0x3101 asserted one cycle after req -> imem_addr stays 0x3000 until ack; stale word never appears on inst_out; next request addr 0x3100; first valid inst_pc=0x3100.
- Buffer full, then redirect, imem_ack and inst_ready all in the same cycle -> inst_valid=0 next cycle; no stale entry; next imem_addr=0x3100.
- redirect_pc=0xFFFF_FFFC, zero-wait memory -> fetches at 0xFFFF_FFFC then 0x0000_0000.
- rst asserted mid-FETCH with ack pending -> next cycle imem_req=0 and inst_valid=0; first post-reset request addr 0x3000; a late ack during IDLE is ignored.
